// File: rtl/cmp_branch_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the compare/branch front end.
package cmp_branch_pkg;

   localparam logic [2:0] OP_CMP = 3'd0;
   localparam logic [2:0] OP_BEQ = 3'd1;
   localparam logic [2:0] OP_BNE = 3'd2;
   localparam logic [2:0] OP_BGT = 3'd3;
   localparam logic [2:0] OP_BLT = 3'd4;
   localparam logic [2:0] OP_BGE = 3'd5;
   localparam logic [2:0] OP_BLE = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_RESP    = 2'd2
   } state_t;

   localparam int FLG_GT = 2;
   localparam int FLG_LT = 1;
   localparam int FLG_EQ = 0;

   function automatic logic is_onehot3(input logic [2:0] f);
      return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
   endfunction

endpackage

// File: rtl/cmp_branch_unit_cond.sv
// Branch condition evaluation: opcode plus latched flags -> taken / flags-invalid error.
module branch_cond_eval
   import cmp_branch_pkg::*;
(
   input  logic [2:0] i_op,
   input  logic [2:0] i_flags,
   input  logic       i_flags_vld,
   output logic       o_taken,
   output logic       o_err
);

   logic w_cond;

   always_comb begin
      w_cond = 1'b0;
      case (i_op)
         OP_BEQ:  w_cond = i_flags[FLG_EQ];
         OP_BNE:  w_cond = ~i_flags[FLG_EQ];
         OP_BGT:  w_cond = i_flags[FLG_GT];
         OP_BLT:  w_cond = i_flags[FLG_LT];
         OP_BGE:  w_cond = i_flags[FLG_GT] | i_flags[FLG_EQ];
         OP_BLE:  w_cond = i_flags[FLG_LT] | i_flags[FLG_EQ];
         default: w_cond = 1'b0;
      endcase
   end

   always_comb begin
      o_taken = 1'b0;
      o_err   = 1'b0;
      if (i_op == OP_JMP) begin
         o_taken = 1'b1;
      end else if (i_op != OP_CMP) begin
         // A conditional branch with no completed compare falls through and flags the error.
         if (i_flags_vld) o_taken = w_cond;
         else             o_err   = 1'b1;
      end
   end

endmodule

// File: rtl/cmp_branch_unit.sv
// Sequential front end to an external magnitude comparator; resolves branches on latched flags
// and hands taken/next-PC to fetch over a valid/ready channel. One op in flight.
module cmp_branch_unit
   import cmp_branch_pkg::*;
#(
   parameter int DATA_W       = 18,
   parameter int ADDR_W       = 18,
   parameter bit CHECK_ONEHOT = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [2:0]        i_in_op,
   input  logic [DATA_W-1:0] i_in_a,
   input  logic [DATA_W-1:0] i_in_b,
   input  logic [ADDR_W-1:0] i_in_pc,
   input  logic [ADDR_W-1:0] i_in_target,
   output logic [DATA_W-1:0] o_cmp_a,
   output logic [DATA_W-1:0] o_cmp_b,
   input  logic              i_cmp_gt,
   input  logic              i_cmp_lt,
   input  logic              i_cmp_eq,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic              o_res_taken,
   output logic [ADDR_W-1:0] o_res_pc,
   output logic              o_res_err,
   output logic [2:0]        o_flags,
   output logic              o_flags_vld,
   output logic              o_cmp_err
);

   localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t      r_state, w_nxt;
   logic        w_accept;
   logic        w_taken, w_err;
   logic [2:0]  w_cmp_res;

   assign o_in_ready  = (r_state == ST_IDLE);
   assign o_res_valid = (r_state == ST_RESP);
   assign w_accept    = i_in_valid & o_in_ready;
   assign w_cmp_res   = {i_cmp_gt, i_cmp_lt, i_cmp_eq};

   branch_cond_eval u_cond (
      .i_op        (i_in_op),
      .i_flags     (o_flags),
      .i_flags_vld (o_flags_vld),
      .o_taken     (w_taken),
      .o_err       (w_err)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_nxt = (i_in_op == OP_CMP) ? ST_COMPARE : ST_RESP;
         ST_COMPARE: w_nxt = ST_IDLE;
         ST_RESP:    if (i_res_ready) w_nxt = ST_IDLE;
         default:    w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_cmp_a     <= '0;
         o_cmp_b     <= '0;
         o_res_taken <= 1'b0;
         o_res_pc    <= '0;
         o_res_err   <= 1'b0;
         o_flags     <= 3'b000;
         o_flags_vld <= 1'b0;
         o_cmp_err   <= 1'b0;
      end else begin
         if (w_accept && (i_in_op == OP_CMP)) begin
            o_cmp_a <= i_in_a;
            o_cmp_b <= i_in_b;
         end
         if (w_accept && (i_in_op != OP_CMP)) begin
            o_res_taken <= w_taken;
            o_res_pc    <= w_taken ? i_in_target : (i_in_pc + PC_INC);
            o_res_err   <= w_err;
         end
         if (r_state == ST_COMPARE) begin
            o_flags     <= w_cmp_res;
            o_flags_vld <= 1'b1;
            // Malformed comparator output is still latched; the sticky bit records it.
            if (CHECK_ONEHOT && !is_onehot3(w_cmp_res)) o_cmp_err <= 1'b1;
         end
      end
   end

endmodule
